shared_counter_sched: RTL and testbench

- Round-robin scheduler that shares one external 8-bit up counter between NUM_REQ requesters.
- Each requester asks for an interval of LEN counts. The scheduler grants one requester at a time, clears the counter, and enables it until it reaches LEN. It then pulses done to the owner and releases the counter.
- Sits between the requesting blocks and the up counter, and drives the counter's enable and clear.

---
 rtl/shared_counter_sched_if.sv | 38 +++
 rtl/shared_counter_sched.sv | 150 +++++++++++++++
 tb/tb_shared_counter_sched.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_counter_sched_if.sv
// Bundle between the requesters, the shared-counter scheduler and the external up counter.
// The aborted signal only exists when SHARED_CTR_ABORT_EN is defined.
interface shared_counter_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] len;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     ctr_enable;
    logic                     ctr_clear;
    logic [CNT_W-1:0]         ctr_out;
`ifdef SHARED_CTR_ABORT_EN
    logic                     aborted;

    // master groups the requesters with the counter; slave is the scheduler itself
    modport master (
        output req, len, ctr_out,
        input  gnt, done, busy, ctr_enable, ctr_clear, aborted
    );
    modport slave (
        input  req, len, ctr_out,
        output gnt, done, busy, ctr_enable, ctr_clear, aborted
    );
`else
    // master groups the requesters with the counter; slave is the scheduler itself
    modport master (
        output req, len, ctr_out,
        input  gnt, done, busy, ctr_enable, ctr_clear
    );
    modport slave (
        input  req, len, ctr_out,
        output gnt, done, busy, ctr_enable, ctr_clear
    );
`endif
endinterface

// File: rtl/shared_counter_sched.sv
// Round-robin scheduler lending one external up counter to NUM_REQ requesters, one interval at a time.
// Optional early termination when the owner drops its request: define SHARED_CTR_ABORT_EN.
module shared_counter_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_counter_sched_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rrPtr_q;
    logic [CNT_W-1:0]   lenLat_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic               clear_q;

    logic [IDX_W-1:0]   pick_d;
    logic               pickValid_d;
    logic [CNT_W-1:0]   pickLen_d;
    logic [IDX_W-1:0]   nextPtr_d;
    logic               reachedLen_d;

    // Two passes give "first set bit at or above the pointer, else first set bit overall".
    always_comb begin
        pick_d      = '0;
        pickValid_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pickValid_d && bus.req[i] && (IDX_W'(i) >= rrPtr_q)) begin
                pickValid_d = 1'b1;
                pick_d      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pickValid_d && bus.req[i]) begin
                pickValid_d = 1'b1;
                pick_d      = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pickLen_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_d == IDX_W'(i)) begin
                pickLen_d = bus.len[i*CNT_W +: CNT_W];
            end
        end
    end

    assign nextPtr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign reachedLen_d = (bus.ctr_out == lenLat_q);

`ifdef SHARED_CTR_ABORT_EN
    logic ownerReq_d;
    logic aborted_q;

    assign ownerReq_d     = bus.req[owner_q];
    assign bus.ctr_enable = (state_q == RUN) && !reachedLen_d && ownerReq_d;
    assign bus.aborted    = aborted_q;
`else
    assign bus.ctr_enable = (state_q == RUN) && !reachedLen_d;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.ctr_clear = clear_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rrPtr_q   <= '0;
            lenLat_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            clear_q   <= 1'b0;
`ifdef SHARED_CTR_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        state_q  <= CLEAR;
                        owner_q  <= pick_d;
                        lenLat_q <= pickLen_d;
                        gnt_q    <= ONE_HOT0 << pick_d;
                        busy_q   <= 1'b1;
                        clear_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    clear_q <= 1'b0;
                    state_q <= RUN;
`ifdef SHARED_CTR_ABORT_EN
                    if (!ownerReq_d) begin
                        state_q   <= DONE;
                        done_q    <= ONE_HOT0 << owner_q;
                        aborted_q <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    // A job that reaches its length counts as complete even if the request drops that same cycle.
                    if (reachedLen_d) begin
                        state_q <= DONE;
                        done_q  <= ONE_HOT0 << owner_q;
                    end
`ifdef SHARED_CTR_ABORT_EN
                    else if (!ownerReq_d) begin
                        state_q   <= DONE;
                        done_q    <= ONE_HOT0 << owner_q;
                        aborted_q <= 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    busy_q  <= 1'b0;
                    rrPtr_q <= nextPtr_d;
`ifdef SHARED_CTR_ABORT_EN
                    aborted_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    gntOneHot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    doneOneHot: assert property (@(posedge clk) disable iff (reset) $onehot0(done_q));

endmodule

// File: tb/tb_shared_counter_sched.sv
// Randomized self-checking bench for shared_counter_sched with a behavioural round-robin model.
// Define SHARED_CTR_ABORT_EN to also exercise the abort path.
module tb_shared_counter_sched;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   modelPtr = 0;
    logic [CNT_W-1:0] ctrVal = '0;

    shared_counter_sched_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    shared_counter_sched #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External 8-bit up counter with synchronous clear
    always @(posedge clk) begin
        if (bus.ctr_clear)
            ctrVal <= '0;
        else if (bus.ctr_enable)
            ctrVal <= ctrVal + 1'b1;
    end
    assign bus.ctr_out = ctrVal;

    function automatic int predict_owner(input logic [NUM_REQ-1:0] r, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (ptr + k) % NUM_REQ;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic set_len(input int i, input int v);
        bus.len[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    function automatic int get_len(input int i);
        return int'(bus.len[i*CNT_W +: CNT_W]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        modelPtr = 0;
    endtask

    // Runs one job already requested by the caller; mode 1 perturbs non-owner inputs, mode 2 rewrites owner len and raises req0.
    task automatic drive_job(input int expOwner, input int expLen, input int mode, input string tag);
        int waitCyc, runCyc, enCount;
        bit seenGnt, seenDone, gntMoved;
        logic [NUM_REQ-1:0] expOh;
        expOh   = NUM_REQ'(1) << expOwner;
        waitCyc = 0;
        seenGnt = 0;
        while (!seenGnt && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
            if (bus.gnt !== '0) seenGnt = 1;
        end
        total++;
        if (!seenGnt) begin
            bad++;
            $display("[TB] FAIL %s grant_timeout: got none want %b", tag, expOh);
            return;
        end
        total++;
        if (waitCyc != 1) begin
            bad++;
            $display("[TB] FAIL %s grant_latency: got %0d want 1", tag, waitCyc);
        end
        total++;
        if (bus.gnt !== expOh) begin
            bad++;
            $display("[TB] FAIL %s gnt: got %b want %b", tag, bus.gnt, expOh);
        end
        total++;
        if ({bus.ctr_clear, bus.ctr_enable, bus.busy} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL %s clear_phase clr/en/busy: got %b want 101", tag,
                     {bus.ctr_clear, bus.ctr_enable, bus.busy});
        end
        runCyc   = 0;
        enCount  = 0;
        seenDone = 0;
        gntMoved = 0;
        while (!seenDone && runCyc < 300) begin
            @(negedge clk);
            runCyc++;
            if (bus.ctr_enable === 1'b1) enCount++;
            if (bus.gnt !== expOh) gntMoved = 1;
            if (bus.done !== '0) seenDone = 1;
            if (!seenDone && runCyc == 2 && mode == 1) begin
                for (int i = 0; i < NUM_REQ; i++) set_len(i, $urandom_range(0, 255));
                bus.req = NUM_REQ'($urandom) | expOh;
            end
            if (!seenDone && runCyc == 2 && mode == 2) begin
                set_len(expOwner, 3);
                bus.req[0] = 1'b1;
            end
        end
        total++;
        if (!seenDone) begin
            bad++;
            $display("[TB] FAIL %s done_timeout: got none want %b", tag, expOh);
            return;
        end
        total++;
        if (bus.done !== expOh) begin
            bad++;
            $display("[TB] FAIL %s done: got %b want %b", tag, bus.done, expOh);
        end
        total++;
        if (gntMoved) begin
            bad++;
            $display("[TB] FAIL %s gnt_hold: got changed want %b", tag, expOh);
        end
        total++;
        if (runCyc != expLen + 2) begin
            bad++;
            $display("[TB] FAIL %s done_time: got %0d want %0d", tag, runCyc, expLen + 2);
        end
        total++;
        if (enCount != expLen) begin
            bad++;
            $display("[TB] FAIL %s enable_cycles: got %0d want %0d", tag, enCount, expLen);
        end
        total++;
        if (int'(bus.ctr_out) != expLen) begin
            bad++;
            $display("[TB] FAIL %s ctr_final: got %0d want %0d", tag, bus.ctr_out, expLen);
        end
`ifdef SHARED_CTR_ABORT_EN
        total++;
        if (bus.aborted !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s aborted: got %b want 0", tag, bus.aborted);
        end
`endif
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.done, bus.busy} !== '0) begin
            bad++;
            $display("[TB] FAIL %s release gnt/done/busy: got %b/%b/%b want 0", tag,
                     bus.gnt, bus.done, bus.busy);
        end
        modelPtr = (expOwner + 1) % NUM_REQ;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = '0;
        bus.len = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.gnt, bus.done, bus.busy, bus.ctr_enable, bus.ctr_clear} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs gnt/done/busy/en/clr: got %b/%b/%b/%b/%b want 0",
                     bus.gnt, bus.done, bus.busy, bus.ctr_enable, bus.ctr_clear);
        end
        reset    = 1'b0;
        modelPtr = 0;
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.busy} !== '0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset gnt/busy: got %b/%b want 0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_single();
        set_len(0, 5);
        bus.req = 4'b0001;
        drive_job(predict_owner(bus.req, modelPtr), 5, 0, "single");
        bus.req = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_len(i, 2);
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            int o;
            o = predict_owner(bus.req, modelPtr);
            drive_job(o, get_len(o), 0, "round_robin");
        end
    endtask

    task automatic test_zero_len();
        set_len(2, 0);
        bus.req = 4'b0100;
        drive_job(predict_owner(bus.req, modelPtr), 0, 0, "zero_len");
        bus.req = '0;
    endtask

    task automatic test_mid_job();
        int o;
        set_len(0, 4);
        set_len(1, 10);
        bus.req = 4'b0010;
        drive_job(predict_owner(bus.req, modelPtr), 10, 2, "mid_job_owner1");
        o = predict_owner(bus.req, modelPtr);
        drive_job(o, get_len(o), 0, "mid_job_next");
        bus.req = '0;
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            int o;
            for (int i = 0; i < NUM_REQ; i++) set_len(i, $urandom_range(0, 20));
            bus.req = NUM_REQ'($urandom_range(1, 15));
            o = predict_owner(bus.req, modelPtr);
            drive_job(o, get_len(o), 1, "random");
        end
        bus.req = '0;
    endtask

    task automatic test_reset_mid_run();
        int guard;
        int o;
        do_reset();
        set_len(2, 9);
        bus.req = 4'b0100;
        guard   = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.busy === 1'b1 && int'(bus.ctr_out) == 4) && guard < 40);
        total++;
        if (guard >= 40) begin
            bad++;
            $display("[TB] FAIL reset_mid_run_reach4: got ctr %0d want 4", bus.ctr_out);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.done, bus.busy, bus.ctr_enable} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run gnt/done/busy/en: got %b/%b/%b/%b want 0",
                     bus.gnt, bus.done, bus.busy, bus.ctr_enable);
        end
        reset    = 1'b0;
        modelPtr = 0;
        for (int i = 0; i < NUM_REQ; i++) set_len(i, 1);
        bus.req = 4'b1111;
        o = predict_owner(bus.req, modelPtr);
        drive_job(o, get_len(o), 0, "after_reset_ptr0");
        bus.req = '0;
    endtask

`ifdef SHARED_CTR_ABORT_EN
    task automatic test_abort();
        int guard;
        do_reset();
        set_len(3, 6);
        bus.req = 4'b1000;
        guard   = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.busy === 1'b1 && bus.ctr_clear === 1'b0 && int'(bus.ctr_out) == 2) && guard < 40);
        bus.req = '0;
        @(negedge clk);
        total++;
        if ({bus.done, bus.aborted} !== 5'b10001) begin
            bad++;
            $display("[TB] FAIL abort done/aborted: got %b/%b want 1000/1", bus.done, bus.aborted);
        end
        repeat (3) @(negedge clk);
        total++;
        if (int'(bus.ctr_out) > 3 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_stop ctr/busy: got %0d/%b want <=3/0", bus.ctr_out, bus.busy);
        end
    endtask
`endif

    initial begin
        bus.req = '0;
        bus.len = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_mid_job();
        test_random();
        test_reset_mid_run();
`ifdef SHARED_CTR_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
